// File: rtl/hack_mem_pkg.sv
// Shared types and address-map constants for the Hack data-memory arbiter.
// Optional feature macro used by the arbiter: HACK_ARB_STARVE_GUARD_EN.
package hack_mem_pkg;

    typedef logic [14:0] addr_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ARB,
        LOCK0,
        LOCK1
    } arb_state_t;

    localparam addr_t SCREEN_BASE = 15'h4000;
    localparam addr_t KBD_ADDR_C  = 15'h6000;

    // Wide enough for any MAX_WAIT in 1..255.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/hack_mem_addr_check.sv
// Combinational Hack address-map check: out-of-range accesses and
// writes to the read-only keyboard word are illegal.
module hack_mem_addr_check
    import hack_mem_pkg::*;
#(
    parameter addr_t ADDR_LIMIT = KBD_ADDR_C,
    parameter addr_t KBD_ADDR   = KBD_ADDR_C
) (
    input  addr_t addr,
    input  logic  we,
    output logic  legal
);

    logic out_of_range;
    logic kbd_write;

    assign out_of_range = (addr > ADDR_LIMIT);
    assign kbd_write    = we && (addr == KBD_ADDR);
    assign legal        = !out_of_range && !kbd_write;

endmodule

// File: rtl/hack_mem_arbiter.sv
// Two-port arbiter for the single-port Hack data memory with locked bursts,
// address-map enforcement and a one-cycle registered response per beat.
// Define HACK_ARB_STARVE_GUARD_EN to enable the port-1 starvation guard.
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter int    MAX_WAIT   = 8,
    parameter addr_t ADDR_LIMIT = 15'h6000,
    parameter addr_t KBD_ADDR   = KBD_ADDR_C
) (
    input  logic  clk,
    input  logic  rst_n,

    input  logic  p0_valid,
    output logic  p0_ready,
    input  logic  p0_we,
    input  logic  p0_lock,
    input  addr_t p0_addr,
    input  word_t p0_wdata,
    output logic  p0_rsp_valid,
    output word_t p0_rsp_data,
    output logic  p0_rsp_err,

    input  logic  p1_valid,
    output logic  p1_ready,
    input  logic  p1_we,
    input  logic  p1_lock,
    input  addr_t p1_addr,
    input  word_t p1_wdata,
    output logic  p1_rsp_valid,
    output word_t p1_rsp_data,
    output logic  p1_rsp_err,

    output addr_t mem_address,
    output word_t mem_in,
    output logic  mem_load,
    input  word_t mem_out
);

    arb_state_t state;
    arb_state_t state_next;

    logic legal0;
    logic legal1;
    logic grant0;
    logic grant1;
    logic starve;

    hack_mem_addr_check #(
        .ADDR_LIMIT (ADDR_LIMIT),
        .KBD_ADDR   (KBD_ADDR)
    ) u_check0 (
        .addr  (p0_addr),
        .we    (p0_we),
        .legal (legal0)
    );

    hack_mem_addr_check #(
        .ADDR_LIMIT (ADDR_LIMIT),
        .KBD_ADDR   (KBD_ADDR)
    ) u_check1 (
        .addr  (p1_addr),
        .we    (p1_we),
        .legal (legal1)
    );

`ifdef HACK_ARB_STARVE_GUARD_EN
    logic [WAIT_W-1:0] wait_cnt;
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    assign starve = (wait_cnt == WAIT_SAT);

    // Only counts port-1 cycles spent waiting; any port-1 accept restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (p1_ready) begin
            wait_cnt <= '0;
        end else if (p1_valid && (wait_cnt != WAIT_SAT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection and lock tracking; a lock is only left by an accepted
    // lock=0 beat, so idle cycles inside a burst keep ownership.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;

        case (state)
            ARB: begin
                if (starve && p1_valid) begin
                    grant1 = 1'b1;
                end else if (p0_valid) begin
                    grant0 = 1'b1;
                end else if (p1_valid) begin
                    grant1 = 1'b1;
                end
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: grant0 = 1'b0;
        endcase

        if (!rst_n) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end

        p0_ready = grant0 && p0_valid;
        p1_ready = grant1 && p1_valid;

        if (p0_ready) begin
            state_next = p0_lock ? LOCK0 : ARB;
        end else if (p1_ready) begin
            state_next = p1_lock ? LOCK1 : ARB;
        end
    end

    // Port 0 owns the memory pins whenever port 1 is not being accepted.
    assign mem_address = p1_ready ? p1_addr  : p0_addr;
    assign mem_in      = p1_ready ? p1_wdata : p0_wdata;
    assign mem_load    = (p0_ready && p0_we && legal0) ||
                         (p1_ready && p1_we && legal1);

    // Read data is captured from the same edge that completes the beat, so a
    // write in one cycle is seen by a read accepted in the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_err   <= 1'b0;
            p0_rsp_data  <= '0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_err   <= 1'b0;
            p1_rsp_data  <= '0;
        end else begin
            p0_rsp_valid <= p0_ready;
            p1_rsp_valid <= p1_ready;
            if (p0_ready) begin
                p0_rsp_err  <= !legal0;
                p0_rsp_data <= (!p0_we && legal0) ? mem_out : '0;
            end
            if (p1_ready) begin
                p1_rsp_err  <= !legal1;
                p1_rsp_data <= (!p1_we && legal1) ? mem_out : '0;
            end
        end
    end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed self-checking bench for hack_mem_arbiter with a behavioural
// 32K x 16 Hack data memory attached to the memory pins.
module tb_hack_mem_arbiter;
    import hack_mem_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  p0_valid, p0_ready, p0_we, p0_lock, p0_rsp_valid, p0_rsp_err;
    addr_t p0_addr;
    word_t p0_wdata, p0_rsp_data;
    logic  p1_valid, p1_ready, p1_we, p1_lock, p1_rsp_valid, p1_rsp_err;
    addr_t p1_addr;
    word_t p1_wdata, p1_rsp_data;
    addr_t mem_address;
    word_t mem_in, mem_out;
    logic  mem_load;

    word_t mem [0:32767];

    int checks;
    int errors;
    int p1_seen;

    hack_mem_arbiter #(
        .MAX_WAIT   (8),
        .ADDR_LIMIT (15'h6000),
        .KBD_ADDR   (15'h6000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_we        (p0_we),
        .p0_lock      (p0_lock),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_data  (p0_rsp_data),
        .p0_rsp_err   (p0_rsp_err),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_we        (p1_we),
        .p1_lock      (p1_lock),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_data  (p1_rsp_data),
        .p1_rsp_err   (p1_rsp_err),
        .mem_address  (mem_address),
        .mem_in       (mem_in),
        .mem_load     (mem_load),
        .mem_out      (mem_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_out = mem[mem_address];

    always @(posedge clk) begin
        if (mem_load) mem[mem_address] <= mem_in;
    end

    task automatic applyStimulus(input int port, input logic valid, input logic we,
                                 input logic lock, input addr_t addr, input word_t wdata);
        if (port == 0) begin
            p0_valid = valid; p0_we = we; p0_lock = lock; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_valid = valid; p1_we = we; p1_lock = lock; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        p1_seen = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[15'h6000] = 16'h00A5;

        // Reset with a write presented: nothing may be accepted or written.
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 15'h0010, 16'h1234);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("reset_p0_ready", p0_ready, 0);
        checkOutput("reset_mem_load", mem_load, 0);
        checkOutput("reset_p0_rsp_valid", p0_rsp_valid, 0);
        checkOutput("reset_p1_rsp_valid", p1_rsp_valid, 0);
        checkOutput("reset_p0_rsp_data", p0_rsp_data, 0);
        checkOutput("reset_p1_rsp_err", p1_rsp_err, 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        tick();

        $display("[TB] write/read back on port 0");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 15'h0010, 16'hBEEF);
        @(negedge clk);
        checkOutput("wr_p0_ready", p0_ready, 1);
        checkOutput("wr_mem_load", mem_load, 1);
        checkOutput("wr_mem_address", mem_address, 15'h0010);
        checkOutput("wr_mem_in", mem_in, 16'hBEEF);
        tick();
        checkOutput("wr_rsp_valid", p0_rsp_valid, 1);
        checkOutput("wr_rsp_data", p0_rsp_data, 0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000);
        @(negedge clk);
        checkOutput("rd_p0_ready", p0_ready, 1);
        checkOutput("rd_mem_load", mem_load, 0);
        tick();
        checkOutput("rd_rsp_valid", p0_rsp_valid, 1);
        checkOutput("rd_rsp_data", p0_rsp_data, 16'hBEEF);
        checkOutput("rd_rsp_err", p0_rsp_err, 0);

        // Idle cycle: port-0 inputs still drive the pins, data holds.
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 15'h1234, 16'h5678);
        @(negedge clk);
        checkOutput("idle_mem_address", mem_address, 15'h1234);
        checkOutput("idle_mem_in", mem_in, 16'h5678);
        checkOutput("idle_mem_load", mem_load, 0);
        tick();
        checkOutput("idle_rsp_valid", p0_rsp_valid, 0);
        checkOutput("idle_rsp_data_hold", p0_rsp_data, 16'hBEEF);

        $display("[TB] address map enforcement");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 15'h6001, 16'h1111);
        @(negedge clk);
        checkOutput("oor_wr_ready", p0_ready, 1);
        checkOutput("oor_wr_mem_load", mem_load, 0);
        tick();
        checkOutput("oor_wr_rsp_err", p0_rsp_err, 1);
        checkOutput("oor_wr_rsp_data", p0_rsp_data, 0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 15'h7FFF, 16'h0000);
        tick();
        checkOutput("oor_rd_rsp_err", p0_rsp_err, 1);
        checkOutput("oor_rd_rsp_data", p0_rsp_data, 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 15'h6000, 16'h2222);
        @(negedge clk);
        checkOutput("kbd_wr_p1_ready", p1_ready, 1);
        checkOutput("kbd_wr_mem_address", mem_address, 15'h6000);
        checkOutput("kbd_wr_mem_load", mem_load, 0);
        tick();
        checkOutput("kbd_wr_rsp_err", p1_rsp_err, 1);
        checkOutput("kbd_wr_rsp_data", p1_rsp_data, 0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 15'h6000, 16'h0000);
        tick();
        checkOutput("kbd_rd_rsp_valid", p1_rsp_valid, 1);
        checkOutput("kbd_rd_rsp_err", p1_rsp_err, 0);
        checkOutput("kbd_rd_rsp_data", p1_rsp_data, 16'h00A5);

        $display("[TB] port-1 locked burst");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 15'h0010, 16'h0000);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 1'b1, 1'b1, (b != 3), 15'h4000 + 15'(b), 16'hA000 + 16'(b));
            if (b > 0) applyStimulus(0, 1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000);
            @(negedge clk);
            checkOutput("burst_p1_ready", p1_ready, 1);
            checkOutput("burst_p0_blocked", p0_ready, 0);
            tick();
            checkOutput("burst_p1_rsp_valid", p1_rsp_valid, 1);
            checkOutput("burst_p1_rsp_err", p1_rsp_err, 0);
        end
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("after_burst_p0_ready", p0_ready, 1);
        tick();
        checkOutput("after_burst_p0_data", p0_rsp_data, 16'hBEEF);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 15'h4002, 16'h0000);
        tick();
        checkOutput("burst_readback", p0_rsp_data, 16'hA002);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        tick();

        applyStimulus(0, 1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 15'h0020, 16'h0000);
`ifdef HACK_ARB_STARVE_GUARD_EN
        $display("[TB] starvation guard");
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) begin
                checkOutput("starve_p1_wins", p1_ready, 1);
                checkOutput("starve_p0_held", p0_ready, 0);
            end else begin
                checkOutput("starve_p0_wins", p0_ready, 1);
                checkOutput("starve_p1_waits", p1_ready, 0);
            end
            tick();
        end
`else
        $display("[TB] strict port-0 priority");
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (p1_ready) p1_seen++;
            checkOutput("strict_p0_wins", p0_ready, 1);
            tick();
        end
        checkOutput("strict_p1_never_ready", p1_seen, 0);
`endif
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        tick();

        $display("[TB] reset during LOCK0");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 15'h0030, 16'hCAFE);
        @(negedge clk);
        checkOutput("lock0_first_ready", p0_ready, 1);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 15'h0030, 16'h0000);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000);
        @(negedge clk);
        checkOutput("lock0_blocks_p1", p1_ready, 0);
        checkOutput("lock0_p0_ready", p0_ready, 1);
        tick();
        checkOutput("lock0_rsp_pending", p0_rsp_valid, 1);
        checkOutput("lock0_rsp_data", p0_rsp_data, 16'hCAFE);
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        #1;
        checkOutput("midlock_reset_rsp_valid", p0_rsp_valid, 0);
        checkOutput("midlock_reset_rsp_data", p0_rsp_data, 0);
        checkOutput("midlock_reset_p1_ready", p1_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_p1_granted", p1_ready, 1);
        checkOutput("post_reset_mem_address", mem_address, 15'h0010);
        tick();
        checkOutput("post_reset_p1_rsp_valid", p1_rsp_valid, 1);
        checkOutput("post_reset_p1_rsp_data", p1_rsp_data, 16'hBEEF);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
